// File: rtl/nios_ii_pio_bidir.sv
// Bidirectional PIO slave for an Avalon-MM bus.
// Provides output set/clear, per-bit direction, edge capture and a masked IRQ.
module nios_ii_pio_bidir #(
  parameter int unsigned      WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  parameter logic [WIDTH-1:0] DIR_RESET   = '0,
  parameter int unsigned      EDGE_TYPE   = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] pio_in,
  output logic [WIDTH-1:0] pio_out,
  output logic [WIDTH-1:0] pio_oe,
  output logic             irq
);

  localparam logic [2:0] A_DATA = 3'd0;
  localparam logic [2:0] A_DIR  = 3'd1;
  localparam logic [2:0] A_MASK = 3'd2;
  localparam logic [2:0] A_EDGE = 3'd3;
  localparam logic [2:0] A_SET  = 3'd4;
  localparam logic [2:0] A_CLR  = 3'd5;

  logic [WIDTH-1:0] out_q,   out_d;
  logic [WIDTH-1:0] dir_q,   dir_d;
  logic [WIDTH-1:0] mask_q,  mask_d;
  logic [WIDTH-1:0] edge_q,  edge_d;
  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;
  logic [WIDTH-1:0] prev_q;
  logic [1:0]       arm_q,   arm_d;
  logic             irq_q,   irq_d;

  logic             wr_en;
  logic [WIDTH-1:0] wdat;
  logic [WIDTH-1:0] clr;
  logic [WIDTH-1:0] edge_raw;
  logic [WIDTH-1:0] hit;
  logic             armed;
  logic             sel_data;
  logic             sel_dir;
  logic             sel_mask;
  logic             sel_edge;
  logic             sel_set;
  logic             sel_clr;
  logic             unused_wd;

  assign wr_en    = chipselect & ~write_n;
  assign wdat     = writedata[WIDTH-1:0];
  assign unused_wd = &{1'b0, writedata};

  assign sel_data = wr_en && (address == A_DATA);
  assign sel_dir  = wr_en && (address == A_DIR);
  assign sel_mask = wr_en && (address == A_MASK);
  assign sel_edge = wr_en && (address == A_EDGE);
  assign sel_set  = wr_en && (address == A_SET);
  assign sel_clr  = wr_en && (address == A_CLR);

  always_comb begin
    out_d  = out_q;
    dir_d  = dir_q;
    mask_d = mask_q;
    clr    = '0;
    unique case (1'b1)
      sel_data: out_d  = wdat;
      sel_dir:  dir_d  = wdat;
      sel_mask: mask_d = wdat;
      sel_edge: clr    = wdat;
      sel_set:  out_d  = out_q | wdat;
      sel_clr:  out_d  = out_q & ~wdat;
      default:  ;
    endcase
  end

  always_comb begin
    unique case (EDGE_TYPE)
      0:       edge_raw = sync_q & ~prev_q;
      1:       edge_raw = ~sync_q & prev_q;
      default: edge_raw = sync_q ^ prev_q;
    endcase
  end

  // Pads may sit high before reset release; hold off capture
  // until the synchroniser and prev stage hold real samples.
  assign armed  = (arm_q == 2'd3);
  assign arm_d  = armed ? arm_q : arm_q + 2'd1;
  assign hit    = armed ? edge_raw : '0;
  assign edge_d = (edge_q & ~clr) | hit;
  assign irq_d  = |(edge_q & mask_q);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_q  <= RESET_VALUE;
      dir_q  <= DIR_RESET;
      mask_q <= '0;
      edge_q <= '0;
      meta_q <= '0;
      sync_q <= '0;
      prev_q <= '0;
      arm_q  <= '0;
      irq_q  <= 1'b0;
    end else begin
      out_q  <= out_d;
      dir_q  <= dir_d;
      mask_q <= mask_d;
      edge_q <= edge_d;
      meta_q <= pio_in;
      sync_q <= meta_q;
      prev_q <= sync_q;
      arm_q  <= arm_d;
      irq_q  <= irq_d;
    end
  end

  always_comb begin
    readdata = '0;
    unique case (address)
      A_DATA:  readdata[WIDTH-1:0] = sync_q;
      A_DIR:   readdata[WIDTH-1:0] = dir_q;
      A_MASK:  readdata[WIDTH-1:0] = mask_q;
      A_EDGE:  readdata[WIDTH-1:0] = edge_q;
      default: ;
    endcase
  end

  assign pio_out = out_q;
  assign pio_oe  = dir_q;
  assign irq     = irq_q;

endmodule

// File: tb/tb_nios_ii_pio_bidir.sv
// Directed self-checking bench for nios_ii_pio_bidir.
// WIDTH=8, RESET_VALUE=A5, DIR_RESET=0F, rising-edge capture.
module tb_nios_ii_pio_bidir;

  logic        clk;
  logic        reset_n;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [7:0]  pio_in;
  logic [7:0]  pio_out;
  logic [7:0]  pio_oe;
  logic        irq;

  int passed;
  int total;

  nios_ii_pio_bidir #(
    .WIDTH(8),
    .RESET_VALUE(8'hA5),
    .DIR_RESET(8'h0F),
    .EDGE_TYPE(0)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .address(address),
    .chipselect(chipselect),
    .write_n(write_n),
    .writedata(writedata),
    .readdata(readdata),
    .pio_in(pio_in),
    .pio_out(pio_out),
    .pio_oe(pio_oe),
    .irq(irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    @(posedge clk);
    #1;
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic rd(input logic [2:0] a, output logic [31:0] d);
    address = a;
    #1;
    d = readdata;
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
    end
    #1;
  endtask

  task automatic set_pin(input logic [7:0] v);
    @(negedge clk);
    pio_in = v;
  endtask

  task automatic test_reset;
    logic [31:0] d;
    reset_n    = 1'b0;
    address    = 3'd0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
    pio_in     = 8'h00;
    #23;
    total++;
    if (pio_out !== 8'hA5)
      $display("FAIL rst_out got %h want a5", pio_out);
    else passed++;
    total++;
    if (pio_oe !== 8'h0F)
      $display("FAIL rst_oe got %h want 0f", pio_oe);
    else passed++;
    total++;
    if (irq !== 1'b0)
      $display("FAIL rst_irq got %b want 0", irq);
    else passed++;
    rd(3'd3, d);
    total++;
    if (d !== 32'h0)
      $display("FAIL rst_edge got %h want 0", d);
    else passed++;
    @(negedge clk);
    reset_n = 1'b1;
    cycles(5);
  endtask

  task automatic test_data_out;
    logic [31:0] d;
    wr(3'd0, 32'hFFFF_FF3C);
    total++;
    if (pio_out !== 8'h3C)
      $display("FAIL wr_data got %h want 3c", pio_out);
    else passed++;
    wr(3'd4, 32'h0000_0001);
    total++;
    if (pio_out !== 8'h3D)
      $display("FAIL outset got %h want 3d", pio_out);
    else passed++;
    wr(3'd5, 32'h0000_000C);
    total++;
    if (pio_out !== 8'h31)
      $display("FAIL outclr got %h want 31", pio_out);
    else passed++;
    rd(3'd4, d);
    total++;
    if (d !== 32'h0)
      $display("FAIL rd_set got %h want 0", d);
    else passed++;
    rd(3'd5, d);
    total++;
    if (d !== 32'h0)
      $display("FAIL rd_clr got %h want 0", d);
    else passed++;
    @(negedge clk);
    address    = 3'd0;
    writedata  = 32'h0000_00FF;
    chipselect = 1'b0;
    write_n    = 1'b0;
    @(posedge clk);
    #1;
    write_n = 1'b1;
    total++;
    if (pio_out !== 8'h31)
      $display("FAIL no_cs_wr got %h want 31", pio_out);
    else passed++;
    wr(3'd6, 32'h0000_00FF);
    wr(3'd7, 32'h0000_00FF);
    total++;
    if (pio_out !== 8'h31)
      $display("FAIL wr_67 got %h want 31", pio_out);
    else passed++;
  endtask

  task automatic test_dir_mask;
    logic [31:0] d;
    wr(3'd1, 32'hABCD_12F0);
    total++;
    if (pio_oe !== 8'hF0)
      $display("FAIL dir_oe got %h want f0", pio_oe);
    else passed++;
    rd(3'd1, d);
    total++;
    if (d !== 32'h0000_00F0)
      $display("FAIL dir_rd got %h want f0", d);
    else passed++;
    wr(3'd2, 32'h0000_0004);
    rd(3'd2, d);
    total++;
    if (d !== 32'h0000_0004)
      $display("FAIL mask_rd got %h want 04", d);
    else passed++;
  endtask

  task automatic test_sync_read;
    logic [31:0] d;
    set_pin(8'h31);
    cycles(1);
    rd(3'd0, d);
    total++;
    if (d !== 32'h0)
      $display("FAIL sync_1cyc got %h want 0", d);
    else passed++;
    cycles(1);
    rd(3'd0, d);
    total++;
    if (d !== 32'h31)
      $display("FAIL sync_2cyc got %h want 31", d);
    else passed++;
    cycles(1);
    rd(3'd3, d);
    total++;
    if (d !== 32'h31)
      $display("FAIL edge_31 got %h want 31", d);
    else passed++;
    wr(3'd3, 32'h0000_00FF);
    rd(3'd3, d);
    total++;
    if (d !== 32'h0)
      $display("FAIL edge_clr got %h want 0", d);
    else passed++;
    cycles(1);
    total++;
    if (irq !== 1'b0)
      $display("FAIL irq_unmasked got %b want 0", irq);
    else passed++;
  endtask

  task automatic test_edge_irq;
    logic [31:0] d;
    set_pin(8'h35);
    cycles(2);
    rd(3'd3, d);
    total++;
    if (d !== 32'h0)
      $display("FAIL edge_early got %h want 0", d);
    else passed++;
    cycles(1);
    rd(3'd3, d);
    total++;
    if (d !== 32'h04)
      $display("FAIL edge_3cyc got %h want 04", d);
    else passed++;
    total++;
    if (irq !== 1'b0)
      $display("FAIL irq_early got %b want 0", irq);
    else passed++;
    cycles(1);
    total++;
    if (irq !== 1'b1)
      $display("FAIL irq_set got %b want 1", irq);
    else passed++;
    wr(3'd3, 32'h0000_0004);
    rd(3'd3, d);
    total++;
    if (d !== 32'h0)
      $display("FAIL edge_wclr got %h want 0", d);
    else passed++;
    total++;
    if (irq !== 1'b1)
      $display("FAIL irq_hold got %b want 1", irq);
    else passed++;
    cycles(1);
    total++;
    if (irq !== 1'b0)
      $display("FAIL irq_drop got %b want 0", irq);
    else passed++;
  endtask

  task automatic test_back_to_back;
    logic [31:0] d;
    wr(3'd2, 32'h0000_0002);
    set_pin(8'h37);
    cycles(4);
    rd(3'd3, d);
    total++;
    if (d !== 32'h02)
      $display("FAIL b1_rise got %h want 02", d);
    else passed++;
    total++;
    if (irq !== 1'b1)
      $display("FAIL b1_irq got %b want 1", irq);
    else passed++;
    set_pin(8'h31);
    cycles(4);
    rd(3'd3, d);
    total++;
    if (d !== 32'h02)
      $display("FAIL fall_ignored got %h want 02", d);
    else passed++;
    set_pin(8'h33);
    @(posedge clk);
    @(posedge clk);
    wr(3'd3, 32'h0000_0002);
    rd(3'd3, d);
    total++;
    if (d !== 32'h02)
      $display("FAIL clr_collide got %h want 02", d);
    else passed++;
    cycles(1);
    total++;
    if (irq !== 1'b1)
      $display("FAIL collide_irq got %b want 1", irq);
    else passed++;
    wr(3'd3, 32'h0000_0002);
    cycles(1);
    rd(3'd3, d);
    total++;
    if (d !== 32'h0)
      $display("FAIL plain_clr got %h want 0", d);
    else passed++;
    total++;
    if (irq !== 1'b0)
      $display("FAIL plain_irq got %b want 0", irq);
    else passed++;
  endtask

  task automatic test_reset_midop;
    logic [31:0] d;
    wr(3'd0, 32'h0000_0012);
    wr(3'd2, 32'h0000_00FF);
    set_pin(8'h00);
    cycles(4);
    set_pin(8'hFF);
    cycles(5);
    rd(3'd3, d);
    total++;
    if (d !== 32'hFF)
      $display("FAIL all_edges got %h want ff", d);
    else passed++;
    total++;
    if (irq !== 1'b1)
      $display("FAIL all_irq got %b want 1", irq);
    else passed++;
    #1;
    reset_n = 1'b0;
    #1;
    total++;
    if (irq !== 1'b0)
      $display("FAIL async_irq got %b want 0", irq);
    else passed++;
    total++;
    if (pio_out !== 8'hA5 || pio_oe !== 8'h0F)
      $display("FAIL async_regs got %h/%h want a5/0f", pio_out, pio_oe);
    else passed++;
    rd(3'd3, d);
    total++;
    if (d !== 32'h0)
      $display("FAIL async_edge got %h want 0", d);
    else passed++;
    rd(3'd2, d);
    total++;
    if (d !== 32'h0)
      $display("FAIL async_mask got %h want 0", d);
    else passed++;
    rd(3'd6, d);
    total++;
    if (d !== 32'h0)
      $display("FAIL rd6 got %h want 0", d);
    else passed++;
  endtask

  task automatic test_arm;
    logic [31:0] d;
    cycles(2);
    @(negedge clk);
    reset_n = 1'b1;
    cycles(6);
    rd(3'd3, d);
    total++;
    if (d !== 32'h0)
      $display("FAIL arm_supp got %h want 0", d);
    else passed++;
    rd(3'd0, d);
    total++;
    if (d !== 32'hFF)
      $display("FAIL arm_sync got %h want ff", d);
    else passed++;
    total++;
    if (irq !== 1'b0)
      $display("FAIL arm_irq got %b want 0", irq);
    else passed++;
    rd(3'd7, d);
    total++;
    if (d !== 32'h0)
      $display("FAIL rd7 got %h want 0", d);
    else passed++;
  endtask

  initial begin
    passed = 0;
    total  = 0;
    test_reset();
    test_data_out();
    test_dir_mask();
    test_sync_read();
    test_edge_irq();
    test_back_to_back();
    test_reset_midop();
    test_arm();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/nios_ii_pio_bidir.md
NIOS_II_PIO_BIDIR -- requirements
Module: nios_ii_pio_bidir

Interface
REQ-001 SHALL provide parameter WIDTH, default 8, number of GPIO bits (legal 1..32).
REQ-002 SHALL provide parameter RESET_VALUE, default 0, reset value of the output data register (WIDTH bits).
REQ-003 SHALL provide parameter DIR_RESET, default 0, reset value of the direction register (1 = output).
REQ-004 SHALL provide parameter EDGE_TYPE, default 0, capture mode: 0 rising, 1 falling, 2 any.
REQ-005 SHALL provide clk  input  1  clock; all state changes on its rising edge.
REQ-006 SHALL provide reset_n  input  1  reset, asynchronous, active-low.
REQ-007 SHALL provide address  input  3  Avalon-MM word offset.
REQ-008 SHALL provide chipselect  input  1  slave select.
REQ-009 SHALL provide write_n  input  1  active-low write strobe.
REQ-010 SHALL provide writedata  input  32  write data.
REQ-011 SHALL provide readdata  output  32  read data, zero wait states.
REQ-012 SHALL provide pio_in  input  WIDTH  pad input, asynchronous to clk.
REQ-013 SHALL provide pio_out  output  WIDTH  pad output data.
REQ-014 SHALL provide pio_oe  output  WIDTH  per-bit output enable to top-level tristate buffer.
REQ-015 SHALL provide irq  output  1  registered active-high interrupt.

Function
REQ-016 SHALL decode a write only when chipselect=1 and write_n=0; register map: 0 DATA, 1 DIRECTION, 2 IRQMASK, 3 EDGECAPTURE, 4 OUTSET, 5 OUTCLEAR; offsets 6-7 read 0, writes ignored.
REQ-017 SHALL, on write to 0, load data_out <= writedata[WIDTH-1:0] next cycle; read of 0 returns synchronised pin state sync_in.
REQ-018 SHALL, on write to 4, set data_out bits where writedata=1; on write to 5, clear those bits; other bits unchanged; offsets 4/5 read 0.
REQ-019 SHALL drive pio_out = data_out and pio_oe = direction register directly from flops.
REQ-020 SHALL pass pio_in through a two-flop synchroniser to sync_in, plus a third stage prev_in, giving 2-cycle pin-to-readdata latency.
REQ-021 SHALL detect per-bit edges from sync_in vs prev_in per EDGE_TYPE, for all bits regardless of direction, and set the corresponding edge_capture bit (sticky).
REQ-022 SHALL clear edge_capture bits where writedata=1 on write to 3; simultaneous clear and new edge on same bit SHALL leave the bit set.
REQ-023 SHALL register irq <= |(edge_capture & irq_mask), one cycle after either operand changes.
REQ-024 SHALL contain an arm counter (2 bits) counting 0..3 from reset release and saturating; edge detection SHALL be suppressed while count < 3 so pre-reset pad levels do not produce captures.
REQ-025 SHALL make readdata combinational from address, upper bits [31:WIDTH] zero; readdata independent of chipselect.
REQ-026 SHALL ignore writedata bits [31:WIDTH] on all registers.

Reset
REQ-027 SHALL on reset_n=0 asynchronously force data_out=RESET_VALUE, direction=DIR_RESET, irq_mask=0, edge_capture=0, irq=0, synchroniser/prev_in=0, arm counter=0.
REQ-028 SHALL, on reset assertion mid-operation, discard pending captures and drop irq in the same instant (no clock needed).

Verification
REQ-029 Reset, WIDTH=8, RESET_VALUE=8'hA5, DIR_RESET=8'h0F -> pio_out=A5, pio_oe=0F, irq=0, read 3 = 0.
REQ-030 Write 0=0x3C, write 4=0x01, write 5=0x0C -> pio_out=0x31; read 0 with pio_in=0x31 held returns 0x31 from 2 cycles after pin settles.
REQ-031 EDGE_TYPE=0, mask=0x04, pio_in[2] 0->1 -> edge_capture=0x04 three cycles later, irq=1 one cycle after; write 3=0x04 -> irq=0 next-next cycle.
REQ-032 pio_in=0xFF held through reset release -> edge_capture stays 0 (arm suppression).
REQ-033 Write 3=0x02 in same cycle as new rising edge on bit 1 -> edge_capture[1] remains 1, irq stays asserted if masked.
REQ-034 Reset asserted while irq=1 and edge_capture=0xFF -> irq=0 and all registers at reset values immediately; read 6 returns 0.
